// File: rtl/seq_mult16.sv
// Unsigned 16x16 shift-and-add multiplier, one multiplier bit per clock,
// built around a 16-bit ripple-carry adder.

module rca16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic c;

    always_comb begin
        s = '0;
        c = cin;
        for (int i = 0; i < 16; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

module seq_mult16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] p
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] acc_hi_q, acc_hi_d;
    logic [15:0] acc_lo_q, acc_lo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] p_q, p_d;

    logic [15:0] add_b;
    logic [15:0] sum;
    logic        carry;

    assign add_b = acc_lo_q[0] ? mcand_q : 16'h0000;

    rca16 u_rca16 (
        .a    (acc_hi_q),
        .b    (add_b),
        .cin  (1'b0),
        .s    (sum),
        .cout (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = (cnt_q == 4'd15) ? DONE : RUN;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // The carry-out shifts into acc_hi[15], so no product bit is ever lost.
    always_comb begin
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        if (state_q == RUN) begin
            acc_hi_d = {carry, sum[15:1]};
            acc_lo_d = {sum[0], acc_lo_q[15:1]};
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                p_d = {carry, sum[15:1], sum[0], acc_lo_q[15:1]};
            end
        end else if (start) begin
            mcand_d  = a;
            acc_lo_d = b;
            acc_hi_d = 16'h0000;
            cnt_d    = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
        end
    end

    assign p = p_q;
endmodule
